button_conditioner: RTL and testbench
=====================================

// Module: button_conditioner
// PURPOSE
//   Front end for the RGB LED controller: takes the four raw, active-low, bouncing board keys,
//   synchronises and debounces each, and drives clean active-high button levels straight into
//   the RGB controller's button_red/green/blue/yellow inputs. Also emits one-cycle press pulses
//   for any future consumer.
// PARAMETERS
//   DEBOUNCE_CYCLES  500000  clk cycles a synced key must differ from its stable state before accepted (10 ms @ 50 MHz); >= 2
//   CNT_W            19      debounce counter width; must satisfy 2**CNT_W >= DEBOUNCE_CYCLES
// PORTS
//   clk            in   1  system clock; all state on rising edge
//   rst_n          in   1  asynchronous active-low reset
//   key_red_n      in   1  raw red key, active-low, asynchronous to clk, bouncing
//   key_green_n    in   1  raw green key, same properties
//   key_blue_n     in   1  raw blue key, same properties
//   key_yellow_n   in   1  raw yellow key, same properties
//   button_red     out  1  conditioned red level, active-high (to RGB controller)
//   button_green   out  1  conditioned green level, active-high
//   button_blue    out  1  conditioned blue level, active-high
//   button_yellow  out  1  conditioned yellow level, active-high
//   press_pulse    out  4  one-cycle pulse per debounced press, bit order {yellow,blue,green,red}
// BEHAVIOUR
//   - Reset (rst_n=0, async): sync flops = 1 (released), stable states = 0, counters = 0,
//     all button_* = 0, press_pulse = 0. Reset asserted mid-count discards the count.
//   - Sync: each key_*_n passes through 2 flops, then is inverted -> synced pressed level p.
//   - Debounce per key, independent: if p == stable: cnt <= 0. If p != stable: cnt <= cnt+1;
//     when cnt == DEBOUNCE_CYCLES-1: stable <= p, cnt <= 0 (same edge).
//   - Any bounce back to stable before the count completes restarts it; glitches shorter than
//     DEBOUNCE_CYCLES cycles never reach outputs. Release is debounced identically to press.
//   - Latency: raw edge to output change = 2 sync + DEBOUNCE_CYCLES cycles, for press and release.
//   - press_pulse[i] = 1 for exactly the cycle after stable[i] goes 0->1; never on release.
//   - Keys fully independent: simultaneous presses yield simultaneous pulses and levels.
//     Priority between colours is the downstream controller's job, not resolved here.
//   - Counters never wrap: bounded by DEBOUNCE_CYCLES-1 < 2**CNT_W.
//   - All outputs registered; no combinational path from key_* to any output.
// CONFIGURATION
//   BTN_LATCH_EN undefined: button_* = debounced stable levels (momentary: held key = level high).
//   BTN_LATCH_EN defined: button_* become a registered one-hot selection held after release.
//     A press pulse on a key sets its button_* to 1, clears the other three on the same edge.
//     Simultaneous pulses resolved red > green > blue > yellow.
//     Releases have no effect. Reset value stays all 0 (nothing selected).
//     press_pulse behaviour identical in both builds.
// TESTING (bench uses DEBOUNCE_CYCLES=8, CNT_W=4)
//   1. Hold rst_n=0, toggle keys -> all outputs 0.
//      Release reset, keys=1 for 20 cycles -> outputs stay 0.
//   2. key_red_n 1->0, held -> button_red=1 exactly 10 cycles later;
//      press_pulse=4'b0001 for 1 cycle. Release -> button_red=0 10 cycles later, no pulse.
//   3. key_green_n low 5 cycles, high 3, low 5 (bounce) -> button_green stays 0.
//      Held low afterwards -> rises 10 cycles after last falling edge.
//   4. key_red_n and key_blue_n fall on same cycle -> button_red and button_blue
//      rise on same cycle; press_pulse=4'b0101.
//   5. Red key held 6 cycles into debounce, rst_n pulsed low 1 cycle -> outputs 0.
//      Full 10-cycle latency counted from reset release.
//   6. BTN_LATCH_EN: press/release blue -> button_blue stays 1.
//      Press yellow -> {yellow,blue,green,red} outputs = 4'b1000.
//      Red+green together -> red only.

Source files
------------

// File: rtl/button_conditioner.sv
// Synchronises and debounces four raw active-low keys into clean active-high button levels
// plus one-cycle press pulses. Define BTN_LATCH_EN to hold a one-hot selection after release.
module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 19
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_red_n,
  input  logic       key_green_n,
  input  logic       key_blue_n,
  input  logic       key_yellow_n,
  output logic       button_red,
  output logic       button_green,
  output logic       button_blue,
  output logic       button_yellow,
  output logic [3:0] press_pulse
);

  localparam int unsigned    NumKeys = 4;
  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NumKeys-1:0] key_raw;
  logic [NumKeys-1:0] sync1_q, sync2_q;
  logic [NumKeys-1:0] pressed;
  logic [NumKeys-1:0] stable_q, stable_d;
  logic [NumKeys-1:0] stable_dly_q;
  logic [NumKeys-1:0] rise;
  logic [NumKeys-1:0] button_q, button_d;
  logic [NumKeys-1:0] pulse_q;
  logic [CNT_W-1:0]   cnt_q [NumKeys];
  logic [CNT_W-1:0]   cnt_d [NumKeys];

  assign key_raw = {key_yellow_n, key_blue_n, key_green_n, key_red_n};

  // Sync flops reset to 1 so a held key looks released until it is genuinely sampled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= key_raw;
      sync2_q <= sync1_q;
    end
  end

  assign pressed = ~sync2_q;

  always_comb begin
    for (int i = 0; i < NumKeys; i++) begin
      stable_d[i] = stable_q[i];
      cnt_d[i]    = '0;
      if (pressed[i] != stable_q[i]) begin
        if (cnt_q[i] == CntMax) begin
          stable_d[i] = pressed[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_q <= '0;
      for (int i = 0; i < NumKeys; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      stable_q <= stable_d;
      for (int i = 0; i < NumKeys; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign rise = stable_q & ~stable_dly_q;

`ifdef BTN_LATCH_EN
  // Lowest index wins on simultaneous presses: red > green > blue > yellow.
  always_comb begin
    button_d = button_q;
    if (rise[0]) begin
      button_d = 4'b0001;
    end else if (rise[1]) begin
      button_d = 4'b0010;
    end else if (rise[2]) begin
      button_d = 4'b0100;
    end else if (rise[3]) begin
      button_d = 4'b1000;
    end
  end
`else
  always_comb begin
    button_d = stable_q;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_dly_q <= '0;
      pulse_q      <= '0;
      button_q     <= '0;
    end else begin
      stable_dly_q <= stable_q;
      pulse_q      <= rise;
      button_q     <= button_d;
    end
  end

  assign button_red    = button_q[0];
  assign button_green  = button_q[1];
  assign button_blue   = button_q[2];
  assign button_yellow = button_q[3];
  assign press_pulse   = pulse_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Randomised and directed bench for button_conditioner against a cycle-level behavioural model.
// Build with BTN_LATCH_EN defined to exercise the latched-selection variant.
module tb_button_conditioner;

  localparam int DC = 8;
  localparam int Latency = DC + 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] kn = 4'b1111;  // {yellow,blue,green,red}, active-low
  logic       button_red, button_green, button_blue, button_yellow;
  logic [3:0] press_pulse;
  logic [3:0] dut_btn;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  button_conditioner #(
    .DEBOUNCE_CYCLES(DC),
    .CNT_W          (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .key_red_n    (kn[0]),
    .key_green_n  (kn[1]),
    .key_blue_n   (kn[2]),
    .key_yellow_n (kn[3]),
    .button_red   (button_red),
    .button_green (button_green),
    .button_blue  (button_blue),
    .button_yellow(button_yellow),
    .press_pulse  (press_pulse)
  );

  assign dut_btn = {button_yellow, button_blue, button_green, button_red};

  // Model: pressed levels travel through a 2-deep delay line; a key's accepted level flips
  // once the delayed level has disagreed with it for DC consecutive cycles; outputs are
  // registered one cycle behind the accepted level.
  logic [3:0] m_delay[$];
  logic [3:0] m_level, m_prev, m_btn, m_pulse;
  int         m_disagree[4];

  function automatic void model_reset();
    m_delay = '{4'b0000, 4'b0000};
    m_level = '0;
    m_prev  = '0;
    m_btn   = '0;
    m_pulse = '0;
    for (int i = 0; i < 4; i++) m_disagree[i] = 0;
  endfunction

  function automatic void model_step(input logic [3:0] keys_n);
    logic [3:0] p, seen;
    p    = m_delay.pop_front();
    seen = m_level;
    for (int i = 0; i < 4; i++) begin
      if (p[i] != m_level[i]) begin
        m_disagree[i]++;
        if (m_disagree[i] == DC) begin
          m_level[i]    = p[i];
          m_disagree[i] = 0;
        end
      end else begin
        m_disagree[i] = 0;
      end
    end
    m_pulse = seen & ~m_prev;
    m_prev  = seen;
`ifdef BTN_LATCH_EN
    if (m_pulse != 0) begin
      if (m_pulse[0])      m_btn = 4'b0001;
      else if (m_pulse[1]) m_btn = 4'b0010;
      else if (m_pulse[2]) m_btn = 4'b0100;
      else                 m_btn = 4'b1000;
    end
`else
    m_btn = seen;
`endif
    m_delay.push_back(~keys_n);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step(kn);
    @(negedge clk);
    check("model_btn", {28'd0, dut_btn}, {28'd0, m_btn});
    check("model_pulse", {28'd0, press_pulse}, {28'd0, m_pulse});
  endtask

  task automatic settle();
    kn = 4'b1111;
    repeat (Latency + 4) tick();
  endtask

  int lat;
  int hold[4];
  bit glitch_seen;

  initial begin
    model_reset();
    // 1. Reset holds outputs low whatever the keys do.
    repeat (6) begin
      kn = 4'($urandom);
      tick();
      check("rst_btn", {28'd0, dut_btn}, 0);
      check("rst_pulse", {28'd0, press_pulse}, 0);
    end
    kn = 4'b1111;
    rst_n = 1'b1;
    repeat (20) tick();
    check("idle_btn", {28'd0, dut_btn}, 0);

    // 2. Single press and release on red.
    kn = 4'b1110;
    tick();
    lat = 0;
    while (!button_red && lat < 30) begin tick(); lat++; end
    check("red_press_lat", lat, Latency);
    check("red_pulse", {28'd0, press_pulse}, 4'b0001);
    tick();
    check("red_pulse_once", {28'd0, press_pulse}, 0);
    repeat (4) tick();
    kn = 4'b1111;
    tick();
`ifdef BTN_LATCH_EN
    repeat (Latency + 4) tick();
    check("red_latched", {31'd0, button_red}, 1);
`else
    lat = 0;
    while (button_red && lat < 30) begin tick(); lat++; end
    check("red_release_lat", lat, Latency);
    check("red_release_pulse", {28'd0, press_pulse}, 0);
`endif
    settle();

    // 3. Bouncing green key: short lows never accepted, final hold accepted.
    glitch_seen = 0;
    kn[1] = 1'b0; repeat (5) begin tick(); glitch_seen |= button_green; end
    kn[1] = 1'b1; repeat (3) begin tick(); glitch_seen |= button_green; end
    kn[1] = 1'b0; tick();
    lat = 0;
    repeat (4) begin tick(); lat++; glitch_seen |= button_green; end
    check("green_bounce", {31'd0, glitch_seen}, 0);
    while (!button_green && lat < 30) begin tick(); lat++; end
    check("green_lat", lat, Latency);
    settle();

    // 4. Simultaneous red and blue.
    kn = 4'b1010;
    tick();
    lat = 0;
    while (!(button_red || button_blue) && lat < 30) begin tick(); lat++; end
    check("rb_lat", lat, Latency);
`ifdef BTN_LATCH_EN
    check("rb_levels", {30'd0, button_blue, button_red}, 2'b01);
`else
    check("rb_levels", {30'd0, button_blue, button_red}, 2'b11);
`endif
    check("rb_pulse", {28'd0, press_pulse}, 4'b0101);
    settle();

    // 5. Reset in the middle of a debounce discards the count.
    kn = 4'b1110;
    repeat (6) tick();
    rst_n = 1'b0;
    model_reset();
    #1;
    check("async_rst", {28'd0, dut_btn}, 0);
    tick();
    check("mid_rst_btn", {28'd0, dut_btn}, 0);
    rst_n = 1'b1;
    tick();
    lat = 0;
    while (!button_red && lat < 30) begin tick(); lat++; end
    check("post_rst_lat", lat, Latency);
    settle();

`ifdef BTN_LATCH_EN
    // 6. Latched selection.
    rst_n = 1'b0; model_reset(); tick(); rst_n = 1'b1;
    kn = 4'b1011; repeat (Latency + 2) tick();
    kn = 4'b1111; repeat (Latency + 4) tick();
    check("latch_blue", {28'd0, dut_btn}, 4'b0100);
    kn = 4'b0111; repeat (Latency + 2) tick();
    check("latch_yellow", {28'd0, dut_btn}, 4'b1000);
    settle();
    kn = 4'b1100; repeat (Latency + 2) tick();
    check("latch_red_green", {28'd0, dut_btn}, 4'b0001);
    settle();
`endif

    // Random bouncing on all keys; each key holds a level for 1..14 cycles.
    for (int i = 0; i < 4; i++) hold[i] = $urandom_range(1, 14);
    repeat (1500) begin
      for (int i = 0; i < 4; i++) begin
        hold[i]--;
        if (hold[i] == 0) begin
          kn[i]   = ~kn[i];
          hold[i] = $urandom_range(1, 14);
        end
      end
      tick();
    end
    settle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
